// File: rtl/led_counter_ctrl.sv
// rtl/led_counter_ctrl.sv - parametrised LED counter with prescaled free-run and debounced single-step
module led_counter_ctrl #(
   parameter int WIDTH        = 16,
   parameter int PRESCALE     = 10_000_000,
   parameter bit SATURATE     = 1'b0,
   parameter int STEP_LOCKOUT = 100_000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             step_btn,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             tc
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int LW = $clog2(STEP_LOCKOUT + 1);
   localparam logic [1:0] MODE_RUN  = 2'b00;
   localparam logic [1:0] MODE_STEP = 2'b01;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [LW-1:0] LOCK_INIT  = LW'(STEP_LOCKOUT);

   logic [PW-1:0]    presc;
   logic             btn_meta;
   logic             btn_sync;
   logic             btn_prev;
   logic [LW-1:0]    lockout;

   logic             run_active;
   logic             free_evt;
   logic             step_rise;
   logic             step_evt;
   logic             cnt_evt;
   logic             halted;
   logic             at_bound;
   logic [WIDTH-1:0] count_next;

   always_comb begin
      run_active = 1'b0;
      free_evt   = 1'b0;
      step_rise  = 1'b0;
      step_evt   = 1'b0;
      cnt_evt    = 1'b0;
      halted     = 1'b0;
      at_bound   = 1'b0;
      count_next = count;

      run_active = en && (mode == MODE_RUN) && !load;
      free_evt   = run_active && (presc == PRESC_LAST);
      step_rise  = btn_sync && !btn_prev;
      // A step is consumed (and lockout armed) even if a load overrides the count update.
      step_evt   = step_rise && en && (mode == MODE_STEP) && (lockout == '0);
      cnt_evt    = free_evt || step_evt;
      halted     = !en || mode[1];

      at_bound = dir ? (count == '0) : (count == '1);
      if (at_bound && SATURATE)
         count_next = count;
      else if (dir)
         count_next = count - WIDTH'(1);
      else
         count_next = count + WIDTH'(1);
   end

   // Prescaler restarts from zero whenever free-run is interrupted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         presc <= '0;
      else if (!run_active || free_evt)
         presc <= '0;
      else
         presc <= presc + PW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         btn_prev <= 1'b0;
      end else begin
         btn_meta <= step_btn;
         btn_sync <= btn_meta;
         btn_prev <= btn_sync;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         lockout <= '0;
      else if (step_evt)
         lockout <= LOCK_INIT;
      else if (lockout != '0)
         lockout <= lockout - LW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         tick  <= 1'b0;
         tc    <= 1'b0;
      end else if (load) begin
         count <= load_value;
         tick  <= 1'b0;
         tc    <= 1'b0;
      end else if (halted) begin
         tick  <= 1'b0;
         tc    <= 1'b0;
      end else if (cnt_evt) begin
         count <= count_next;
         tick  <= free_evt;
         tc    <= at_bound;
      end else begin
         tick  <= 1'b0;
         tc    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_led_counter_ctrl.sv
// tb/tb_led_counter_ctrl.sv - scoreboard bench for led_counter_ctrl, wrap and saturate builds
module tb_led_counter_ctrl;

   typedef struct {
      logic [3:0] c;
      logic       t;
      logic       tc;
   } exp_t;

   logic       clk;
   logic       reset_n;
   logic       en;
   logic       dir;
   logic [1:0] mode;
   logic       load;
   logic [3:0] load_value;
   logic       step_btn;
   logic [3:0] count;
   logic       tick;
   logic       tc;
   logic [3:0] s_count;
   logic       s_tick;
   logic       s_tc;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   bit   chk_sat = 1'b0;

   led_counter_ctrl #(.WIDTH(4), .PRESCALE(4), .SATURATE(1'b0), .STEP_LOCKOUT(8)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .mode(mode), .load(load),
      .load_value(load_value), .step_btn(step_btn), .count(count), .tick(tick), .tc(tc)
   );

   led_counter_ctrl #(.WIDTH(4), .PRESCALE(4), .SATURATE(1'b1), .STEP_LOCKOUT(8)) dut_sat (
      .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .mode(mode), .load(load),
      .load_value(load_value), .step_btn(step_btn), .count(s_count), .tick(s_tick), .tc(s_tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   function automatic logic [5:0] obs();
      return chk_sat ? {s_count, s_tick, s_tc} : {count, tick, tc};
   endfunction

   task automatic test_reset;
      exp_t e;
      reset_n = 1'b0; en = 1'b0; dir = 1'b0; mode = 2'b00;
      load = 1'b0; load_value = 4'd0; step_btn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      e.c = 4'd0; e.t = 1'b0; e.tc = 1'b0;
      sbq.push_back(e);
      sbq.push_back(e);
      e = sbq.pop_front();
      total++;
      if ({count, tick, tc} !== {e.c, e.t, e.tc}) begin
         bad++;
         $display("FAIL reset_wrap: got %b want %b", {count, tick, tc}, {e.c, e.t, e.tc});
      end
      e = sbq.pop_front();
      total++;
      if ({s_count, s_tick, s_tc} !== {e.c, e.t, e.tc}) begin
         bad++;
         $display("FAIL reset_sat: got %b want %b", {s_count, s_tick, s_tc}, {e.c, e.t, e.tc});
      end
      reset_n = 1'b1;
   endtask

   task automatic test_freerun;
      exp_t e;
      chk_sat = 1'b0;
      en = 1'b1; mode = 2'b00; dir = 1'b0; load = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         e.c = 4'((k / 4) % 16); e.t = (k % 4 == 0); e.tc = (k == 64);
         sbq.push_back(e);
      end
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk); #1;
         e = sbq.pop_front();
         total++;
         if (obs() !== {e.c, e.t, e.tc}) begin
            bad++;
            $display("FAIL freerun edge %0d: got %b want %b", k, obs(), {e.c, e.t, e.tc});
         end
      end
   endtask

   task automatic test_load_down;
      exp_t e;
      chk_sat = 1'b0;
      load = 1'b1; load_value = 4'd2; dir = 1'b1;
      e.c = 4'd2; e.t = 1'b0; e.tc = 1'b0;
      sbq.push_back(e);
      for (int j = 1; j <= 12; j++) begin
         e.c = 4'(2 - j / 4); e.t = (j % 4 == 0); e.tc = (j == 12);
         sbq.push_back(e);
      end
      for (int j = 0; j <= 12; j++) begin
         @(posedge clk); #1;
         load = 1'b0;
         e = sbq.pop_front();
         total++;
         if (obs() !== {e.c, e.t, e.tc}) begin
            bad++;
            $display("FAIL load_down edge %0d: got %b want %b", j, obs(), {e.c, e.t, e.tc});
         end
      end
   endtask

   task automatic test_saturate;
      exp_t e;
      chk_sat = 1'b1;
      load = 1'b1; load_value = 4'd14; dir = 1'b0;
      e.c = 4'd14; e.t = 1'b0; e.tc = 1'b0;
      sbq.push_back(e);
      for (int j = 1; j <= 16; j++) begin
         e.c = (j < 4) ? 4'd14 : 4'd15; e.t = (j % 4 == 0); e.tc = (j % 4 == 0) && (j >= 8);
         sbq.push_back(e);
      end
      for (int j = 0; j <= 16; j++) begin
         @(posedge clk); #1;
         load = 1'b0;
         e = sbq.pop_front();
         total++;
         if (obs() !== {e.c, e.t, e.tc}) begin
            bad++;
            $display("FAIL saturate edge %0d: got %b want %b", j, obs(), {e.c, e.t, e.tc});
         end
      end
      chk_sat = 1'b0;
   endtask

   task automatic test_step;
      exp_t e;
      chk_sat = 1'b0;
      load = 1'b1; load_value = 4'd0; dir = 1'b0; mode = 2'b01;
      @(posedge clk); #1;
      load = 1'b0;
      e.c = 4'd0; e.t = 1'b0; e.tc = 1'b0;
      sbq.push_back(e);
      e = sbq.pop_front();
      total++;
      if (obs() !== {e.c, e.t, e.tc}) begin
         bad++;
         $display("FAIL step_load: got %b want %b", obs(), {e.c, e.t, e.tc});
      end
      // Pulses start at 0, 6 (inside lockout), 20 and 40; accepted ones land 3 edges later.
      for (int i = 0; i < 60; i++) begin
         e.c = 4'(int'(i + 1 >= 3) + int'(i + 1 >= 23) + int'(i + 1 >= 43));
         e.t = 1'b0; e.tc = 1'b0;
         sbq.push_back(e);
      end
      for (int i = 0; i < 60; i++) begin
         step_btn = (i == 0 || i == 1 || i == 6 || i == 7 || i == 20 || i == 21 || i == 40 || i == 41);
         @(posedge clk); #1;
         e = sbq.pop_front();
         total++;
         if (obs() !== {e.c, e.t, e.tc}) begin
            bad++;
            $display("FAIL step edge %0d: got %b want %b", i + 1, obs(), {e.c, e.t, e.tc});
         end
      end
      step_btn = 1'b0;
   endtask

   task automatic test_pause;
      exp_t e;
      chk_sat = 1'b0;
      load = 1'b1; load_value = 4'd0; dir = 1'b0; mode = 2'b00; en = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      for (int j = 1; j <= 26; j++) begin
         e.c = (j < 4) ? 4'd0 : (j < 8) ? 4'd1 : (j < 16) ? 4'd2 : (j < 24) ? 4'd3 : 4'd4;
         e.t = (j == 4 || j == 8 || j == 16 || j == 24); e.tc = 1'b0;
         sbq.push_back(e);
      end
      for (int j = 1; j <= 26; j++) begin
         en   = !(j == 11 || j == 12);
         mode = (j == 19 || j == 20) ? 2'b10 : 2'b00;
         @(posedge clk); #1;
         e = sbq.pop_front();
         total++;
         if (obs() !== {e.c, e.t, e.tc}) begin
            bad++;
            $display("FAIL pause edge %0d: got %b want %b", j, obs(), {e.c, e.t, e.tc});
         end
      end
      en = 1'b1; mode = 2'b00;
   endtask

   task automatic test_async_reset;
      exp_t e;
      chk_sat = 1'b0;
      load = 1'b1; load_value = 4'd9;
      e.c = 4'd9; e.t = 1'b0; e.tc = 1'b0;
      for (int j = 0; j < 3; j++) sbq.push_back(e);
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); #1;
         load = 1'b0;
         e = sbq.pop_front();
         total++;
         if (obs() !== {e.c, e.t, e.tc}) begin
            bad++;
            $display("FAIL pre_reset edge %0d: got %b want %b", j, obs(), {e.c, e.t, e.tc});
         end
      end
      #2;
      reset_n = 1'b0;
      #1;
      e.c = 4'd0; e.t = 1'b0; e.tc = 1'b0;
      sbq.push_back(e);
      e = sbq.pop_front();
      total++;
      if ({count, tick, tc} !== {e.c, e.t, e.tc}) begin
         bad++;
         $display("FAIL async_reset: got %b want %b", {count, tick, tc}, {e.c, e.t, e.tc});
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         e.c = 4'(j / 4); e.t = (j % 4 == 0); e.tc = 1'b0;
         sbq.push_back(e);
      end
      for (int j = 1; j <= 8; j++) begin
         @(posedge clk); #1;
         e = sbq.pop_front();
         total++;
         if (obs() !== {e.c, e.t, e.tc}) begin
            bad++;
            $display("FAIL post_reset edge %0d: got %b want %b", j, obs(), {e.c, e.t, e.tc});
         end
      end
   endtask

   initial begin
      test_reset();
      test_freerun();
      test_load_down();
      test_saturate();
      test_step();
      test_pause();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
